// File: rtl/bpsk_burst_modulator_pkg.sv
// Shared types and constants for the BPSK burst modulator.
// Width defaults normally arrive from params.svh; the guards keep that header authoritative.
`ifndef ADC_BITS
`define ADC_BITS 12
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 64
`endif

package bpsk_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2
   } bpsk_state_e;

   // Preamble alternates starting from this bit: 1,0,1,0,...
   localparam logic PREAMBLE_FIRST_BIT = 1'b1;

   // Internal cosine table precision, resized to the output width afterwards.
   localparam int LUT_WIDTH = 16;

   function automatic logic preamble_bit(input logic idx_lsb);
      return PREAMBLE_FIRST_BIT ^ idx_lsb;
   endfunction

endpackage

// File: rtl/bpsk_burst_modulator_lut.sv
// Full-period cosine table, amplitude 2^(DATA_WIDTH-1)-1, with READ_PORTS
// independent combinational read ports.
module cosine_lut #(
   parameter int PHASE_WIDTH = 6,
   parameter int DATA_WIDTH  = 16,
   parameter int READ_PORTS  = 1
) (
   input  logic [READ_PORTS-1:0][PHASE_WIDTH-1:0] i_addr,
   output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  o_data
);

   localparam int DEPTH = 2 ** PHASE_WIDTH;

   typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] table_t;

   function automatic table_t build_table();
      table_t t;
      real    amp;
      real    ang;
      real    v;
      amp = real'((2 ** (DATA_WIDTH - 1)) - 1);
      for (int i = 0; i < DEPTH; i++) begin
         ang  = 2.0 * 3.14159265358979323846 * real'(i) / real'(DEPTH);
         v    = amp * $cos(ang);
         // Round half away from zero so the table is symmetric about zero.
         t[i] = (v >= 0.0) ? DATA_WIDTH'($rtoi(v + 0.5)) : DATA_WIDTH'(-$rtoi(0.5 - v));
      end
      return t;
   endfunction

   localparam table_t TABLE = build_table();

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      assign o_data[p] = TABLE[i_addr[p]];
   end

endmodule

// File: rtl/bpsk_burst_modulator.sv
// BPSK burst modulator: alternating preamble then data symbols, carrier from a
// phase accumulator into a cosine table; symbol 1 shifts the phase by half a period.
module bpsk_burst_modulator
   import bpsk_pkg::*;
#(
   parameter int OUT_WIDTH          = `ADC_BITS,
   parameter int PHASE_WIDTH        = $clog2(`CARRIER_SAMPLES_PER_PERIOD),
   parameter int SAMPLES_PER_SYMBOL = 16,
   parameter int PREAMBLE_SYMBOLS   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PHASE_WIDTH-1:0] phase_step,
   input  logic                   bit_valid,
   input  logic                   bit_data,
   output logic                   bit_ready,
   output logic [OUT_WIDTH-1:0]   sample,
   output logic                   sample_valid,
   output logic                   symbol_strobe,
   output logic                   busy
);

   localparam int SC_W = $clog2(SAMPLES_PER_SYMBOL);
   localparam int PC_W = (PREAMBLE_SYMBOLS > 1) ? $clog2(PREAMBLE_SYMBOLS) : 1;

   bpsk_state_e            r_state;
   bpsk_state_e            w_next_state;
   logic [PHASE_WIDTH-1:0] r_step;
   logic [PHASE_WIDTH-1:0] r_phase;
   logic [SC_W-1:0]        r_sym_cnt;
   logic [PC_W-1:0]        r_pre_cnt;
   logic                   r_pending;
   logic                   r_armed;
   logic [OUT_WIDTH-1:0]   r_sample;
   logic                   r_sample_valid;
   logic                   r_strobe;

   logic                   w_xfer;
   logic                   w_sym_last;
   logic                   w_pre_last;
   logic                   w_symbol;
   logic [0:0][PHASE_WIDTH-1:0] w_lut_addr;
   logic [0:0][LUT_WIDTH-1:0]   w_lut_data;
   logic signed [LUT_WIDTH-1:0] w_lut_s;
   logic signed [OUT_WIDTH-1:0] w_resized;

   assign w_xfer     = bit_valid & bit_ready;
   assign w_sym_last = (r_sym_cnt == SC_W'(SAMPLES_PER_SYMBOL - 1));
   assign w_pre_last = (PREAMBLE_SYMBOLS <= 1) ? 1'b1
                     : (r_pre_cnt == PC_W'(PREAMBLE_SYMBOLS - 1));
   assign w_symbol   = (r_state == PREAMBLE) ? preamble_bit(r_pre_cnt[0]) : r_pending;

   // Adding half a period to the phase negates the cosine.
   assign w_lut_addr[0] = r_phase + (PHASE_WIDTH'(w_symbol) << (PHASE_WIDTH - 1));

   cosine_lut #(
      .PHASE_WIDTH (PHASE_WIDTH),
      .DATA_WIDTH  (LUT_WIDTH),
      .READ_PORTS  (1)
   ) u_lut (
      .i_addr (w_lut_addr),
      .o_data (w_lut_data)
   );

   assign w_lut_s = signed'(w_lut_data[0]);

   if (OUT_WIDTH >= LUT_WIDTH) begin : g_ext
      assign w_resized = OUT_WIDTH'(w_lut_s);
   end else begin : g_trunc
      localparam logic signed [OUT_WIDTH-1:0] MOST_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      logic signed [OUT_WIDTH-1:0] w_trunc;
      assign w_trunc = OUT_WIDTH'(w_lut_s >>> (LUT_WIDTH - OUT_WIDTH));
      // Flooring can land on the most negative code; keep the output symmetric.
      assign w_resized = (w_trunc == MOST_NEG) ? MOST_NEG + OUT_WIDTH'(1) : w_trunc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:     if (w_xfer) w_next_state = (PREAMBLE_SYMBOLS == 0) ? DATA : PREAMBLE;
         PREAMBLE: if (w_sym_last && w_pre_last) w_next_state = DATA;
         DATA:     if (w_sym_last && !w_xfer) w_next_state = IDLE;
         default:  w_next_state = IDLE;
      endcase
   end

   always_comb begin
      bit_ready = 1'b0;
      busy      = 1'b0;
      case (r_state)
         IDLE:     bit_ready = r_armed;
         PREAMBLE: busy = 1'b1;
         DATA: begin
            busy      = 1'b1;
            bit_ready = w_sym_last;
         end
         default: ;
      endcase
   end

   // r_armed holds bit_ready low until the first clock after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_armed   <= 1'b0;
         r_step    <= '0;
         r_phase   <= '0;
         r_sym_cnt <= '0;
         r_pre_cnt <= '0;
         r_pending <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  r_pending <= bit_data;
                  r_step    <= phase_step;
                  r_phase   <= '0;
                  r_sym_cnt <= '0;
                  r_pre_cnt <= '0;
               end
            end
            default: begin
               r_phase <= r_phase + r_step;
               if (w_sym_last) begin
                  r_sym_cnt <= '0;
                  if (r_state == PREAMBLE) r_pre_cnt <= r_pre_cnt + 1'b1;
                  else if (w_xfer)         r_pending <= bit_data;
               end else begin
                  r_sym_cnt <= r_sym_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sample       <= '0;
         r_sample_valid <= 1'b0;
         r_strobe       <= 1'b0;
      end else begin
         r_sample       <= (r_state != IDLE) ? w_resized : '0;
         r_sample_valid <= (r_state != IDLE);
         r_strobe       <= (r_state != IDLE) && (r_sym_cnt == '0);
      end
   end

   assign sample        = r_sample;
   assign sample_valid  = r_sample_valid;
   assign symbol_strobe = r_strobe;

endmodule

// File: tb/tb_bpsk_burst_modulator.sv
// Scoreboard bench: two modulators (default preamble, no preamble) share clock and reset.
module tb_bpsk_burst_modulator;

   typedef struct {
      int val;
      bit strb;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] step_a, step_b;
   logic       vld_a, dat_a, vld_b, dat_b;
   logic       rdy_a, rdy_b;
   logic [11:0] smp_a, smp_b;
   logic       sv_a, sv_b, st_a, st_b, busy_a, busy_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int   checks = 0;
   int   failures = 0;
   int   cnt_a = 0;
   int   cnt_b = 0;
   int   rdy_busy_a = 0;
   int   cyc = 0;
   int   xfer_cyc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   bpsk_burst_modulator dut_a (
      .clk(clk), .rst(rst), .phase_step(step_a), .bit_valid(vld_a), .bit_data(dat_a),
      .bit_ready(rdy_a), .sample(smp_a), .sample_valid(sv_a), .symbol_strobe(st_a), .busy(busy_a)
   );

   bpsk_burst_modulator #(.PREAMBLE_SYMBOLS(0)) dut_b (
      .clk(clk), .rst(rst), .phase_step(step_b), .bit_valid(vld_b), .bit_data(dat_b),
      .bit_ready(rdy_b), .sample(smp_b), .sample_valid(sv_b), .symbol_strobe(st_b), .busy(busy_b)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Hand-derived 12-bit cosine for a 64-entry period at quarter-period points.
   function automatic int cos_q(input int idx);
      case (idx % 64)
         0:       return 2047;
         16:      return 0;
         32:      return -2047;
         48:      return 0;
         default: return -99999;
      endcase
   endfunction

   task automatic push_burst(input bit which, input int pre, input int step,
                             input logic [7:0] bits, input int nbits);
      exp_t e;
      int   n;
      bit   sym;
      for (int s = 0; s < pre + nbits; s++) begin
         sym = (s < pre) ? (s % 2 == 0) : bits[s - pre];
         for (int pos = 0; pos < 16; pos++) begin
            n      = s * 16 + pos;
            e.val  = cos_q(n * step + (sym ? 32 : 0));
            e.strb = (pos == 0);
            if (which) q_b.push_back(e);
            else       q_a.push_back(e);
         end
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (sv_a) begin
         cnt_a++;
         if (q_a.size() == 0) check("a_unexpected_sample", 1, 0);
         else begin
            e = q_a.pop_front();
            check("a_sample", $signed(smp_a), e.val);
            check("a_strobe", st_a, e.strb);
         end
      end
      if (sv_b) begin
         cnt_b++;
         if (q_b.size() == 0) check("b_unexpected_sample", 1, 0);
         else begin
            e = q_b.pop_front();
            check("b_sample", $signed(smp_b), e.val);
            check("b_strobe", st_b, e.strb);
         end
      end
      if (busy_a && rdy_a) rdy_busy_a++;
   end

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send(input bit which, input bit b);
      int n = 0;
      if (which) begin vld_b = 1'b1; dat_b = b; end
      else       begin vld_a = 1'b1; dat_a = b; end
      while (!(which ? rdy_b : rdy_a) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check("send_timeout", 1, 0);
      @(posedge clk);
      xfer_cyc = cyc;
      @(negedge clk);
   endtask

   task automatic wait_idle(input bit which, input int bound);
      int n = 0;
      while ((which ? busy_b : busy_a) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", (n >= bound) ? 1 : 0, 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, t0, t1, t2, r0, n;
      rst = 1'b1;
      step_a = 6'd0; step_b = 6'd0;
      vld_a = 1'b0; dat_a = 1'b0; vld_b = 1'b0; dat_b = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sample", smp_a, 0);
      check("rst_valid", sv_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_ready", rdy_a, 0);
      check("rst_strobe", st_a, 0);
      rst = 1'b0;
      #1;
      check("ready_before_first_clk", rdy_a, 0);
      @(posedge clk); #1;
      check("ready_after_first_clk", rdy_a, 1);
      check("ready_after_first_clk_b", rdy_b, 1);
      @(negedge clk);

      // Single data bit 0 behind the default preamble.
      step_a = 6'd16;
      push_burst(1'b0, 8, 16, 8'b0, 1);
      base = cnt_a;
      send(1'b0, 1'b0);
      vld_a = 1'b0;
      wait_idle(1'b0, 400);
      check("t1_count", cnt_a - base, 144);
      check("t1_queue_empty", q_a.size(), 0);
      check("t1_idle_valid", sv_a, 0);
      check("t1_idle_sample", smp_a, 0);
      check("t1_idle_ready", rdy_a, 1);

      // Back-to-back data bits 1,1,0.
      push_burst(1'b0, 8, 16, 8'b0000_0011, 3);
      base = cnt_a;
      r0 = rdy_busy_a;
      send(1'b0, 1'b1); t0 = xfer_cyc;
      send(1'b0, 1'b1); t1 = xfer_cyc;
      send(1'b0, 1'b0); t2 = xfer_cyc;
      vld_a = 1'b0;
      wait_idle(1'b0, 400);
      check("t2_gap_first", t1 - t0, 144);
      check("t2_gap_second", t2 - t1, 16);
      check("t2_ready_pulses", rdy_busy_a - r0, 3);
      check("t2_count", cnt_a - base, 176);
      check("t2_queue_empty", q_a.size(), 0);

      // Zero phase step: constant level per symbol.
      step_a = 6'd0;
      push_burst(1'b0, 8, 0, 8'b1, 1);
      base = cnt_a;
      send(1'b0, 1'b1);
      vld_a = 1'b0;
      wait_idle(1'b0, 400);
      check("t3_count", cnt_a - base, 144);

      // Step changed mid-burst must not alter the sequence.
      step_a = 6'd16;
      push_burst(1'b0, 8, 16, 8'b1, 1);
      base = cnt_a;
      send(1'b0, 1'b1);
      vld_a = 1'b0;
      repeat (40) @(negedge clk);
      step_a = 6'd8;
      wait_idle(1'b0, 400);
      check("t4_count", cnt_a - base, 144);
      check("t4_queue_empty", q_a.size(), 0);

      // Reset at sample 100 aborts the burst.
      step_a = 6'd16;
      push_burst(1'b0, 8, 16, 8'b0, 1);
      base = cnt_a;
      send(1'b0, 1'b0);
      vld_a = 1'b0;
      n = 0;
      while (cnt_a - base < 100 && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      check("t5_reach_100", cnt_a - base, 100);
      #2 rst = 1'b1;
      #1;
      check("t5_abort_valid", sv_a, 0);
      check("t5_abort_busy", busy_a, 0);
      check("t5_abort_sample", smp_a, 0);
      check("t5_abort_ready", rdy_a, 0);
      q_a.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      check("t5_no_samples_after", cnt_a - base, 100);
      check("t5_idle_busy", busy_a, 0);

      // No-preamble instance: one bit 1.
      step_b = 6'd16;
      push_burst(1'b1, 0, 16, 8'b1, 1);
      base = cnt_b;
      send(1'b1, 1'b1);
      vld_b = 1'b0;
      wait_idle(1'b1, 100);
      check("t6_count", cnt_b - base, 16);
      check("t6_queue_empty", q_b.size(), 0);
      check("t6_idle_valid", sv_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
